klotski_tile_mover: RTL and testbench

Responder side of the solver's move-request handshake for the 4x4 sliding-tile (klotski) engine. It accepts a board, a lock mask, a tile number and a target cell. It moves that tile to the target by greedily routing the blank around it, one blank step per cycle. It then returns the updated board and mask with the target cell locked, and pulses `o_finished` for the sequencing FSM above it.

---
 rtl/klotski_tile_mover.sv | 258 +++++++++++++++++++++++++
 tb/tb_klotski_tile_mover.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/klotski_tile_mover.sv
// Move-request responder for the 4x4 klotski engine: walks one tile to its
// target by routing the blank around it greedily, one blank step per cycle.
module klotski_tile_mover #(
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_klotski,
    input  logic [15:0] i_mask,
    input  logic [3:0]  i_number,
    input  logic [3:0]  i_target,
    input  logic        i_flag,
    output logic [63:0] o_klotski,
    output logic [15:0] o_mask,
    output logic        o_finished,
    output logic        o_error,
    output logic        o_busy,
    output logic        o_move_valid,
    output logic [1:0]  o_move_dir,
    output logic [7:0]  o_step_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCATE,
        S_BLANK,
        S_SWAP,
        S_DONE
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    state_t      state, state_next;
    logic [63:0] board_r;
    logic [15:0] mask_r;
    logic [3:0]  number_r, target_r, last_target_r;
    logic [3:0]  next_r, prev_r;
    logic        prev_valid_r, err_r;
    logic        move_valid_r;
    logic [1:0]  move_dir_r;
    logic [7:0]  step_cnt_r;

    logic [3:0]  tile_pos, blank_pos;
    logic        tile_found, blank_found;

    // Priority pick: preferred vertical, preferred horizontal, then U/D/L/R.
    function automatic logic [2:0] pick(input logic [3:0] ok,
                                        input logic pv_en, input logic [1:0] pv_dir,
                                        input logic ph_en, input logic [1:0] ph_dir);
        logic [2:0] r;
        r = 3'b000;
        if (pv_en && ok[pv_dir])      r = {1'b1, pv_dir};
        else if (ph_en && ok[ph_dir]) r = {1'b1, ph_dir};
        else if (ok[0])               r = {1'b1, DIR_UP};
        else if (ok[1])               r = {1'b1, DIR_DOWN};
        else if (ok[2])               r = {1'b1, DIR_LEFT};
        else if (ok[3])               r = {1'b1, DIR_RIGHT};
        return r;
    endfunction

    always_comb begin
        tile_pos    = '0;
        tile_found  = 1'b0;
        blank_pos   = '0;
        blank_found = 1'b0;
        for (int unsigned c = 0; c < 16; c++) begin
            if (board_r[c*4 +: 4] == number_r) begin
                tile_pos   = 4'(c);
                tile_found = 1'b1;
            end
            if (board_r[c*4 +: 4] == 4'd0) begin
                blank_pos   = 4'(c);
                blank_found = 1'b1;
            end
        end
    end

    // Next cell for the tile, chosen once per tile step.
    logic [3:0] hn, vn, loc_next;
    logic       loc_err, loc_at_target;

    always_comb begin
        hn            = (tile_pos[1:0] > target_r[1:0]) ? tile_pos - 4'd1 : tile_pos + 4'd1;
        vn            = (tile_pos[3:2] > target_r[3:2]) ? tile_pos - 4'd4 : tile_pos + 4'd4;
        loc_next      = '0;
        loc_err       = 1'b0;
        loc_at_target = 1'b0;
        if (number_r == 4'd0 || !tile_found || !blank_found) begin
            loc_err = 1'b1;
        end else if (tile_pos == target_r) begin
            loc_at_target = 1'b1;
        end else if (tile_pos[1:0] != target_r[1:0] && !mask_r[hn]) begin
            loc_next = hn;
        end else if (tile_pos[3:2] != target_r[3:2] && !mask_r[vn]) begin
            loc_next = vn;
        end else begin
            loc_err = 1'b1;
        end
    end

    // Blank step selection toward next_r.
    logic [3:0] cand [4];
    logic [3:0] in_grid, legal, fresh;
    logic [2:0] sel_fresh, sel_any, sel;
    logic [3:0] mv_cell;
    logic       pv_en, ph_en;
    logic [1:0] pv_dir, ph_dir;
    logic [1:0] swap_dir;
    logic       budget_hit;

    always_comb begin
        cand[0] = blank_pos - 4'd4;
        cand[1] = blank_pos + 4'd4;
        cand[2] = blank_pos - 4'd1;
        cand[3] = blank_pos + 4'd1;
        in_grid = {blank_pos[1:0] != 2'd3, blank_pos[1:0] != 2'd0,
                   blank_pos[3:2] != 2'd3, blank_pos[3:2] != 2'd0};
        legal   = '0;
        fresh   = '0;
        for (int unsigned d = 0; d < 4; d++) begin
            legal[d] = in_grid[d] && !mask_r[cand[d]] && (cand[d] != tile_pos);
            fresh[d] = legal[d] && !(prev_valid_r && cand[d] == prev_r);
        end
        pv_en     = blank_pos[3:2] != next_r[3:2];
        pv_dir    = (next_r[3:2] < blank_pos[3:2]) ? DIR_UP : DIR_DOWN;
        ph_en     = blank_pos[1:0] != next_r[1:0];
        ph_dir    = (next_r[1:0] < blank_pos[1:0]) ? DIR_LEFT : DIR_RIGHT;
        sel_fresh = pick(fresh, pv_en, pv_dir, ph_en, ph_dir);
        sel_any   = pick(legal, pv_en, pv_dir, ph_en, ph_dir);
        // The cell just vacated is only reused when nothing else is legal.
        sel       = sel_fresh[2] ? sel_fresh : sel_any;
        mv_cell   = cand[sel[1:0]];

        if (tile_pos == blank_pos - 4'd4)      swap_dir = DIR_UP;
        else if (tile_pos == blank_pos + 4'd4) swap_dir = DIR_DOWN;
        else if (tile_pos == blank_pos - 4'd1) swap_dir = DIR_LEFT;
        else                                   swap_dir = DIR_RIGHT;

        budget_hit = {24'd0, step_cnt_r} >= MAX_STEPS;
    end

    logic latch, loc_ok, err_set, blank_move, swap, lock;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        loc_ok     = 1'b0;
        err_set    = 1'b0;
        blank_move = 1'b0;
        swap       = 1'b0;
        lock       = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    latch      = 1'b1;
                    state_next = S_LOCATE;
                end
            end
            S_LOCATE: begin
                if (loc_err) begin
                    err_set    = 1'b1;
                    state_next = S_DONE;
                end else if (loc_at_target) begin
                    lock       = 1'b1;
                    state_next = S_DONE;
                end else begin
                    loc_ok     = 1'b1;
                    state_next = S_BLANK;
                end
            end
            S_BLANK: begin
                if (blank_pos == next_r) begin
                    state_next = S_SWAP;
                end else if (!sel[2] || budget_hit) begin
                    err_set    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    blank_move = 1'b1;
                end
            end
            S_SWAP: begin
                swap       = 1'b1;
                state_next = S_LOCATE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            board_r       <= '0;
            mask_r        <= '0;
            number_r      <= '0;
            target_r      <= '0;
            last_target_r <= '0;
            next_r        <= '0;
            prev_r        <= '0;
            prev_valid_r  <= 1'b0;
            err_r         <= 1'b0;
            move_valid_r  <= 1'b0;
            move_dir_r    <= '0;
            step_cnt_r    <= '0;
        end else begin
            move_valid_r <= blank_move | swap;
            if (latch) begin
                board_r    <= i_klotski;
                mask_r     <= i_mask & ~(16'(i_flag) << last_target_r);
                number_r   <= i_number;
                target_r   <= i_target;
                step_cnt_r <= '0;
                err_r      <= 1'b0;
            end
            if (loc_ok) begin
                next_r       <= loc_next;
                prev_valid_r <= 1'b0;
            end
            if (blank_move) begin
                board_r[{blank_pos, 2'b00} +: 4] <= board_r[{mv_cell, 2'b00} +: 4];
                board_r[{mv_cell, 2'b00} +: 4]   <= '0;
                prev_r                           <= blank_pos;
                prev_valid_r                     <= 1'b1;
            end
            if (swap) begin
                board_r[{blank_pos, 2'b00} +: 4] <= number_r;
                board_r[{tile_pos, 2'b00} +: 4]  <= '0;
            end
            if (blank_move || swap) begin
                move_dir_r <= swap ? swap_dir : sel[1:0];
                if (step_cnt_r != '1) step_cnt_r <= step_cnt_r + 8'd1;
            end
            if (err_set) err_r <= 1'b1;
            if (lock) begin
                mask_r[target_r] <= 1'b1;
                last_target_r    <= target_r;
            end
        end
    end

    assign o_klotski    = board_r;
    assign o_mask       = mask_r;
    assign o_finished   = (state == S_DONE);
    assign o_error      = (state == S_DONE) && err_r;
    assign o_busy       = (state != S_IDLE);
    assign o_move_valid = move_valid_r;
    assign o_move_dir   = move_dir_r;
    assign o_step_cnt   = step_cnt_r;

endmodule

// File: tb/tb_klotski_tile_mover.sv
// Scoreboard bench for klotski_tile_mover: expected boards, masks and blank
// directions are queued at request time and retired as the DUT reports them.
module tb_klotski_tile_mover;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] klotski = '0;
    logic [15:0] mask = '0;
    logic [3:0]  number = '0;
    logic [3:0]  target = '0;
    logic        flag_in = 1'b0;
    logic [63:0] o_klotski;
    logic [15:0] o_mask;
    logic        o_finished, o_error, o_busy, o_move_valid;
    logic [1:0]  o_move_dir;
    logic [7:0]  o_step_cnt;

    klotski_tile_mover #(.MAX_STEPS(255)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_klotski   (klotski),
        .i_mask      (mask),
        .i_number    (number),
        .i_target    (target),
        .i_flag      (flag_in),
        .o_klotski   (o_klotski),
        .o_mask      (o_mask),
        .o_finished  (o_finished),
        .o_error     (o_error),
        .o_busy      (o_busy),
        .o_move_valid(o_move_valid),
        .o_move_dir  (o_move_dir),
        .o_step_cnt  (o_step_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] board;
        logic [15:0] mask;
        logic        err;
        logic [7:0]  steps;
    } res_t;

    res_t       exp_q[$];
    logic [1:0] dir_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    localparam logic [63:0] SOLVED   = 64'h0FED_CBA9_8765_4321;
    localparam logic [63:0] ONE_SWAP = 64'hF0ED_CBA9_8765_4321;
    localparam logic [63:0] DETOUR   = 64'h0FED_CBA9_8765_4312;
    localparam logic [63:0] DET_END  = 64'hCFED_8BA9_4652_3701;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("err_outside_done", 64'(o_error & ~o_finished), 64'd0);
            if (o_move_valid) begin
                check("move_expected", 64'(dir_q.size() != 0), 64'd1);
                if (dir_q.size() != 0)
                    check("move_dir", 64'(o_move_dir), 64'(dir_q.pop_front()));
            end
            if (o_finished) begin
                check("fin_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("fin_board", o_klotski, r.board);
                    check("fin_mask", 64'(o_mask), 64'(r.mask));
                    check("fin_error", 64'(o_error), 64'(r.err));
                    check("fin_steps", 64'(o_step_cnt), 64'(r.steps));
                end
            end
        end
    end

    task automatic request(input string name, input logic [63:0] b, input logic [15:0] m,
                           input logic [3:0] num, input logic [3:0] tgt, input logic flag,
                           input logic [63:0] eb, input logic [15:0] em, input logic ee,
                           input logic [7:0] es, input int lat, input bit poke);
        res_t r;
        int   n;
        r.board = eb;
        r.mask  = em;
        r.err   = ee;
        r.steps = es;
        exp_q.push_back(r);
        @(negedge clk);
        klotski = b;
        mask    = m;
        number  = num;
        target  = tgt;
        flag_in = flag;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_busy"}, 64'(o_busy), 64'd1);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (poke && n == 3) begin
                start   = 1'b1;
                klotski = '1;
                number  = 4'd9;
            end
            if (poke && n == 4) start = 1'b0;
            if (o_finished) break;
        end
        check({name, "_finished"}, 64'(o_finished), 64'd1);
        if (lat >= 0) check({name, "_latency"}, 64'(n), 64'(lat));
        @(posedge clk);
        #1;
        check({name, "_pulse"}, 64'(o_finished), 64'd0);
        check({name, "_idle"}, 64'(o_busy), 64'd0);
        check({name, "_hold"}, o_klotski, eb);
    endtask

    task automatic push_detour_dirs();
        dir_q.push_back(2'd0);
        dir_q.push_back(2'd0);
        dir_q.push_back(2'd0);
        dir_q.push_back(2'd2);
        dir_q.push_back(2'd1);
        dir_q.push_back(2'd2);
        dir_q.push_back(2'd2);
        dir_q.push_back(2'd0);
        dir_q.push_back(2'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_board", o_klotski, 64'd0);
        check("reset_mask", 64'(o_mask), 64'd0);
        check("reset_ctl", 64'({o_finished, o_error, o_move_valid, o_move_dir, o_step_cnt}), 64'd0);

        request("placed", SOLVED, 16'h0000, 4'd1, 4'd0, 1'b0,
                SOLVED, 16'h0001, 1'b0, 8'd0, 1, 1'b0);
        request("noflag", SOLVED, 16'h0001, 4'd2, 4'd1, 1'b0,
                SOLVED, 16'h0003, 1'b0, 8'd0, 1, 1'b0);
        request("flag", SOLVED, 16'h0003, 4'd3, 4'd2, 1'b1,
                SOLVED, 16'h0005, 1'b0, 8'd0, 1, 1'b0);

        push_detour_dirs();
        request("detour", DETOUR, 16'h0000, 4'd1, 4'd0, 1'b0,
                DET_END, 16'h0001, 1'b0, 8'd9, -1, 1'b1);

        request("boxed", DETOUR, 16'h4800, 4'd1, 4'd0, 1'b0,
                DETOUR, 16'h4800, 1'b1, 8'd0, 2, 1'b0);

        dir_q.push_back(2'd3);
        request("one_swap", ONE_SWAP, 16'h0000, 4'd15, 4'd14, 1'b0,
                SOLVED, 16'h4000, 1'b0, 8'd1, -1, 1'b0);

        // Abort mid-route: three blank moves land, then reset.
        push_detour_dirs();
        @(negedge clk);
        klotski = DETOUR;
        mask    = 16'h0000;
        number  = 4'd1;
        target  = 4'd0;
        flag_in = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_steps", 64'(o_step_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        dir_q.delete();
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_board", o_klotski, 64'd0);
        check("midrst_mask", 64'(o_mask), 64'd0);
        check("midrst_ctl", 64'({o_finished, o_error, o_move_valid, o_move_dir, o_step_cnt}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle", 64'(o_busy), 64'd0);

        // last_target returns to 0 after reset, so the flag clears bit 0.
        dir_q.push_back(2'd3);
        request("swap_after_rst", ONE_SWAP, 16'h0001, 4'd15, 4'd14, 1'b1,
                SOLVED, 16'h4000, 1'b0, 8'd1, -1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("results_drained", 64'(exp_q.size()), 64'd0);
        check("moves_drained", 64'(dir_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
